// File: rtl/cond_pkg.sv
// Condition-code encodings, flag bit positions and the packed flag type
// shared by the flag unit and its condition decoder.
package cond_pkg;

  // Bit positions inside flags_t, packed as {V, Z, N, C}.
  localparam int FLAG_V = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  typedef logic [3:0] flags_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  function automatic flags_t pack_flags(input logic v, input logic z,
                                        input logic n, input logic c);
    flags_t f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Purely combinational ARM-style condition decoder: evaluates a condition
// code against a packed {V,Z,N,C} flag word.
module cond_eval
  import cond_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] cond,
  input  flags_t            flags,
  output logic              true
);

  logic [3:0] code;
  logic       v, z, n, c;

  always_comb begin
    // Only the low four bits carry an encoding; narrower fields zero-extend.
    code = 4'(cond);
    v    = flags[FLAG_V];
    z    = flags[FLAG_Z];
    n    = flags[FLAG_N];
    c    = flags[FLAG_C];
  end

  always_comb begin
    true = 1'b0;
    case (code)
      COND_EQ: true = z;
      COND_NE: true = !z;
      COND_CS: true = c;
      COND_CC: true = !c;
      COND_MI: true = n;
      COND_PL: true = !n;
      COND_VS: true = v;
      COND_VC: true = !v;
      COND_HI: true = c && !z;
      COND_LS: true = !c || z;
      COND_GE: true = (n == v);
      COND_LT: true = (n != v);
      COND_GT: true = !z && (n == v);
      COND_LE: true = z || (n != v);
      COND_AL: true = 1'b1;
      COND_NV: true = 1'b0;
      default: true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag register with one-deep shadow and a registered condition evaluator (latency 1).
// Define COND_FLAG_BYPASS_EN to evaluate against the flags being written this edge.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_v,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              upd_valid,
  input  logic              s_bit,
  input  logic              save,
  input  logic              restore,
  input  logic              cond_req,
  input  logic [COND_W-1:0] cond,
  output logic              vin,
  output logic              zin,
  output logic              nin,
  output logic              cin,
  output logic              cond_valid,
  output logic              cond_true
);

  flags_t flags_q, flags_d;
  flags_t shadow_q, shadow_d;
  logic   cond_valid_q, cond_valid_d;
  logic   cond_true_q, cond_true_d;

  flags_t alu_flags;
  flags_t flags_nxt;
  flags_t eval_flags;
  logic   eval_true;

  // Restore wins over a retiring update; save always captures the pre-edge
  // flags, so save+restore together swaps the two registers.
  always_comb begin
    alu_flags = pack_flags(alu_v, alu_z, alu_n, alu_c);
    flags_nxt = flags_q;
    if (restore) begin
      flags_nxt = shadow_q;
    end else if (upd_valid && s_bit) begin
      flags_nxt = alu_flags;
    end
  end

`ifdef COND_FLAG_BYPASS_EN
  assign eval_flags = flags_nxt;
`else
  assign eval_flags = flags_q;
`endif

  cond_eval #(
    .COND_W(COND_W)
  ) u_cond_eval (
    .cond  (cond),
    .flags (eval_flags),
    .true  (eval_true)
  );

  always_comb begin
    flags_d      = flags_nxt;
    shadow_d     = save ? flags_q : shadow_q;
    cond_valid_d = cond_req;
    cond_true_d  = cond_req ? eval_true : cond_true_q;
    if (reset) begin
      flags_d      = '0;
      shadow_d     = '0;
      cond_valid_d = 1'b0;
      cond_true_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    flags_q      <= flags_d;
    shadow_q     <= shadow_d;
    cond_valid_q <= cond_valid_d;
    cond_true_q  <= cond_true_d;
  end

  assign vin        = flags_q[FLAG_V];
  assign zin        = flags_q[FLAG_Z];
  assign nin        = flags_q[FLAG_N];
  assign cin        = flags_q[FLAG_C];
  assign cond_valid = cond_valid_q;
  assign cond_true  = cond_true_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios plus randomized traffic
// against a behavioural model of the flag, shadow and condition rules.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_v, alu_z, alu_n, alu_c;
  logic       upd_valid, s_bit, save, restore, cond_req;
  logic [3:0] cond;
  logic       vin, zin, nin, cin;
  logic       cond_valid, cond_true;
  logic [3:0] dut_flags;

  int n_vec = 0;
  int n_bad = 0;

  // Model state, flags packed as {V,Z,N,C}
  logic [3:0] m_flags, m_shadow;
  logic       m_cv, m_ct;

  always #5 clk = ~clk;

  assign dut_flags = {vin, zin, nin, cin};

  cond_flag_unit #(.COND_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_v      (alu_v),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .upd_valid  (upd_valid),
    .s_bit      (s_bit),
    .save       (save),
    .restore    (restore),
    .cond_req   (cond_req),
    .cond       (cond),
    .vin        (vin),
    .zin        (zin),
    .nin        (nin),
    .cin        (cin),
    .cond_valid (cond_valid),
    .cond_true  (cond_true)
  );

  function automatic logic ref_cond(input int code, input logic [3:0] f);
    logic v, z, n, c;
    v = f[3]; z = f[2]; n = f[1]; c = f[0];
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c & !z;
      9:  return !c | z;
      10: return n == v;
      11: return n != v;
      12: return !z & (n == v);
      13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
  task automatic apply(input logic rst, input logic upd, input logic s,
                       input logic sv, input logic rs, input logic req,
                       input logic [3:0] vznc, input logic [3:0] cc);
    logic [3:0] next_f, eval_f;
    reset = rst; upd_valid = upd; s_bit = s; save = sv; restore = rs;
    cond_req = req; cond = cc;
    {alu_v, alu_z, alu_n, alu_c} = vznc;
    next_f = rs ? m_shadow : ((upd && s) ? vznc : m_flags);
`ifdef COND_FLAG_BYPASS_EN
    eval_f = next_f;
`else
    eval_f = m_flags;
`endif
    if (rst) begin
      m_flags = 4'b0; m_shadow = 4'b0; m_cv = 1'b0; m_ct = 1'b0;
    end else begin
      if (sv) m_shadow = m_flags;
      if (req) m_ct = ref_cond(int'(cc), eval_f);
      m_cv    = req;
      m_flags = next_f;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 0, 1, 4'b1111, 4'hE);
    apply(1, 0, 0, 0, 0, 0, 4'b0000, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=%b", dut_flags, 4'b0000);
    end
    n_vec++;
    if (cond_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_cond_valid got=%b exp=0", cond_valid);
    end
    n_vec++;
    if (cond_true !== 1'b0) begin
      n_bad++; $display("FAIL reset_cond_true got=%b exp=0", cond_true);
    end
  endtask

  task automatic test_update();
    apply(0, 1, 1, 0, 0, 0, 4'b0100, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b0100) begin
      n_bad++; $display("FAIL upd_load got=%b exp=%b", dut_flags, 4'b0100);
    end
    apply(0, 0, 0, 0, 0, 1, 4'b0000, 4'h0);
    n_vec++;
    if (cond_valid !== 1'b1 || cond_true !== 1'b1) begin
      n_bad++; $display("FAIL eq_result got=%b%b exp=11", cond_valid, cond_true);
    end
    apply(0, 1, 0, 0, 0, 0, 4'b0011, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b0100) begin
      n_bad++; $display("FAIL upd_no_sbit got=%b exp=%b", dut_flags, 4'b0100);
    end
    n_vec++;
    if (cond_valid !== 1'b0 || cond_true !== 1'b1) begin
      n_bad++; $display("FAIL idle_hold got=%b%b exp=01", cond_valid, cond_true);
    end
    apply(0, 0, 0, 0, 0, 1, 4'b0000, 4'h1);
    n_vec++;
    if (cond_valid !== 1'b1 || cond_true !== 1'b0) begin
      n_bad++; $display("FAIL ne_result got=%b%b exp=10", cond_valid, cond_true);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [4];
    logic       exp   [4];
    codes = '{4'hA, 4'hB, 4'hC, 4'hD};
    exp   = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply(0, 1, 1, 0, 0, 0, 4'b0010, 4'h0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 1, 4'b0000, codes[i]);
      n_vec++;
      if (cond_valid !== 1'b1 || cond_true !== exp[i]) begin
        n_bad++;
        $display("FAIL signed_b2b cond=%h got=%b%b exp=1%b", codes[i], cond_valid, cond_true, exp[i]);
      end
    end
  endtask

  task automatic test_shadow();
    apply(0, 1, 1, 0, 0, 0, 4'b1000, 4'h0);
    apply(0, 0, 0, 1, 0, 0, 4'b0000, 4'h0);
    apply(0, 1, 1, 0, 0, 0, 4'b0001, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b0001) begin
      n_bad++; $display("FAIL shadow_upd got=%b exp=%b", dut_flags, 4'b0001);
    end
    apply(0, 1, 1, 0, 1, 0, 4'b0110, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b1000) begin
      n_bad++; $display("FAIL restore_prio got=%b exp=%b", dut_flags, 4'b1000);
    end
    apply(0, 1, 1, 0, 0, 0, 4'b0011, 4'h0);
    apply(0, 0, 0, 1, 1, 0, 4'b0000, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b1000) begin
      n_bad++; $display("FAIL swap_flags got=%b exp=%b", dut_flags, 4'b1000);
    end
    apply(0, 0, 0, 0, 1, 0, 4'b0000, 4'h0);
    n_vec++;
    if (dut_flags !== 4'b0011) begin
      n_bad++; $display("FAIL swap_shadow got=%b exp=%b", dut_flags, 4'b0011);
    end
  endtask

  task automatic test_bypass();
    logic exp_ct;
`ifdef COND_FLAG_BYPASS_EN
    exp_ct = 1'b1;
`else
    exp_ct = 1'b0;
`endif
    apply(0, 1, 1, 0, 0, 0, 4'b0000, 4'h0);
    apply(0, 1, 1, 0, 0, 1, 4'b0100, 4'h0);
    n_vec++;
    if (cond_valid !== 1'b1 || cond_true !== exp_ct) begin
      n_bad++; $display("FAIL bypass_eq got=%b%b exp=1%b", cond_valid, cond_true, exp_ct);
    end
    n_vec++;
    if (dut_flags !== 4'b0100) begin
      n_bad++; $display("FAIL bypass_flags got=%b exp=%b", dut_flags, 4'b0100);
    end
  endtask

  task automatic test_reset_req();
    apply(0, 1, 1, 0, 0, 1, 4'b1111, 4'hE);
    apply(1, 0, 0, 0, 0, 1, 4'b0000, 4'hE);
    n_vec++;
    if (cond_valid !== 1'b0 || dut_flags !== 4'b0000 || cond_true !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_drops_req got cv=%b ct=%b flags=%b exp cv=0 ct=0 flags=0000", cond_valid, cond_true, dut_flags);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(31) == 0), $urandom_range(1), $urandom_range(1),
            ($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom_range(1),
            4'($urandom_range(15)), 4'($urandom_range(15)));
      n_vec++;
      if (dut_flags !== m_flags || cond_valid !== m_cv || cond_true !== m_ct) begin
        n_bad++;
        $display("FAIL random_%0d got flags=%b cv=%b ct=%b exp flags=%b cv=%b ct=%b", i, dut_flags, cond_valid, cond_true, m_flags, m_cv, m_ct);
      end
    end
  endtask

  initial begin
    reset = 1'b1; upd_valid = 1'b0; s_bit = 1'b0; save = 1'b0; restore = 1'b0;
    cond_req = 1'b0; cond = 4'h0;
    {alu_v, alu_z, alu_n, alu_c} = 4'b0000;
    m_flags = 4'b0; m_shadow = 4'b0; m_cv = 1'b0; m_ct = 1'b0;
    test_reset();
    test_update();
    test_back_to_back();
    test_shadow();
    test_bypass();
    test_reset_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
